// File: rtl/lsu_dmem_master.sv
// RV32I load/store unit front end: turns byte/half/word requests into word-only
// memory cycles, using read-modify-write for partial stores and splitting accesses that straddle two words.
module lsu_dmem_master #(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [2:0]  mem_mask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4,
        RESP = 3'd5
    } state_t;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        logic [2:0] s;
        case (f3[1:0])
            2'b00:   s = 3'd1;
            2'b01:   s = 3'd2;
            default: s = 3'd4;
        endcase
        return s;
    endfunction

    function automatic logic is_span(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] last;
        last = {2'b00, off} + {1'b0, size_of(f3)} - 4'd1;
        return (last > 4'd3);
    endfunction

    // Byte enables across the two-word window {w0+1, w0}.
    function automatic logic [7:0] be_of(input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    function automatic logic [63:0] data_of(input logic [31:0] wd, input logic [1:0] off);
        return {32'd0, wd} << {off, 3'b000};
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = data[8*k +: 8];
            end else begin
                res[8*k +: 8] = old[8*k +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] hi, input logic [31:0] lo,
                                                input logic [1:0] off, input logic [2:0] f3);
        logic [63:0] sh;
        logic [31:0] r;
        sh = {hi, lo} >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b010:  r = sh[31:0];
            3'b100:  r = {24'd0, sh[7:0]};
            3'b101:  r = {16'd0, sh[15:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic is_illegal(input logic st, input logic [2:0] f3, input logic span);
        logic ill;
        case (f3)
            3'b011, 3'b110, 3'b111: ill = 1'b1;
            default:                ill = (st & f3[2]) | (span & ~MISALIGN_EN);
        endcase
        return ill;
    endfunction

    state_t      state_r;
    logic        store_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] buf0_r;
    logic [31:0] buf1_r;

    logic [1:0]  off_s;
    logic        span_s;
    logic [7:0]  be_s;
    logic [63:0] data_s;
    logic [29:0] w0_s;
    logic [29:0] w1_s;
    logic        req_span_s;
    logic        req_illegal_s;
    logic        req_aligned_sw_s;

    assign off_s            = addr_r[1:0];
    assign span_s           = is_span(funct3_r, off_s);
    assign be_s             = be_of(funct3_r, off_s);
    assign data_s           = data_of(wdata_r, off_s);
    assign w0_s             = addr_r[31:2];
    assign w1_s             = w0_s + 30'd1;
    assign req_span_s       = is_span(req_funct3, req_addr[1:0]);
    assign req_illegal_s    = is_illegal(req_store, req_funct3, req_span_s);
    assign req_aligned_sw_s = req_store & (req_funct3 == 3'b010) & (req_addr[1:0] == 2'b00);

    assign mem_mask = 3'b010;

    // Request sequencer: state, request latches, read buffers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            store_r     <= 1'b0;
            funct3_r    <= 3'd0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            buf0_r      <= 32'd0;
            buf1_r      <= 32'd0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'd0;
            mem_addr    <= 32'd0;
            mem_wr_data <= 32'd0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
        end else begin
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'd0;
            mem_addr    <= 32'd0;
            mem_wr_data <= 32'd0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        store_r  <= req_store;
                        funct3_r <= req_funct3;
                        addr_r   <= req_addr;
                        wdata_r  <= req_wdata;
                        if (req_illegal_s) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_aligned_sw_s) begin
                            state_r     <= WR0;
                            mem_wr      <= 1'b1;
                            mem_addr    <= {req_addr[31:2], 2'b00};
                            mem_wr_data <= req_wdata;
                        end else begin
                            state_r  <= RD0;
                            mem_rd   <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD0: begin
                    buf0_r <= mem_rdata;
                    if (span_s) begin
                        state_r  <= RD1;
                        mem_rd   <= 1'b1;
                        mem_addr <= {w1_s, 2'b00};
                    end else if (store_r) begin
                        state_r     <= WR0;
                        mem_wr      <= 1'b1;
                        mem_addr    <= {w0_s, 2'b00};
                        mem_wr_data <= merge_word(mem_rdata, data_s[31:0], be_s[3:0]);
                    end else begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_extend(32'd0, mem_rdata, off_s, funct3_r);
                    end
                end
                RD1: begin
                    buf1_r <= mem_rdata;
                    if (store_r) begin
                        state_r     <= WR0;
                        mem_wr      <= 1'b1;
                        mem_addr    <= {w0_s, 2'b00};
                        mem_wr_data <= merge_word(buf0_r, data_s[31:0], be_s[3:0]);
                    end else begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_extend(mem_rdata, buf0_r, off_s, funct3_r);
                    end
                end
                WR0: begin
                    if (span_s) begin
                        state_r     <= WR1;
                        mem_wr      <= 1'b1;
                        mem_addr    <= {w1_s, 2'b00};
                        mem_wr_data <= merge_word(buf1_r, data_s[63:32], be_s[7:4]);
                    end else begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                WR1: begin
                    state_r    <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: two instances (split and error-on-misalign) against a
// byte-addressed reference memory, with directed and random load/store traffic.
module tb_lsu_dmem_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid [2];
    logic        resp_err [2];
    logic [31:0] resp_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wr_data [2];
    logic        mem_wr [2];
    logic        mem_rd [2];
    logic [2:0]  mem_mask [2];
    logic [31:0] mem_rdata [2];

    logic [31:0] mem [2][16];
    logic [7:0]  rb [2][64];
    logic        pl_en;
    int          pl_d;
    logic [3:0]  pl_idx;
    logic [31:0] pl_val;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;
    int          last_lat;
    logic        last_err;

    lsu_dmem_master #(.MISALIGN_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_err(resp_err[0]), .resp_rdata(resp_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_wr_data(mem_wr_data[0]), .mem_wr(mem_wr[0]), .mem_rd(mem_rd[0]),
        .mem_mask(mem_mask[0]), .mem_rdata(mem_rdata[0])
    );

    lsu_dmem_master #(.MISALIGN_EN(1'b0)) u_dut_na (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_err(resp_err[1]), .resp_rdata(resp_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_wr_data(mem_wr_data[1]), .mem_wr(mem_wr[1]), .mem_rd(mem_rd[1]),
        .mem_mask(mem_mask[1]), .mem_rdata(mem_rdata[1])
    );

    // Memories: 16 words each, combinational read, commit on the falling edge.
    assign mem_rdata[0] = mem[0][mem_addr[0][5:2]];
    assign mem_rdata[1] = mem[1][mem_addr[1][5:2]];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_wr[d]) mem[d][mem_addr[d][5:2]] <= mem_wr_data[d];
        end
        if (pl_en) mem[pl_d][pl_idx] <= pl_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int d, input int idx);
        return {rb[d][idx*4+3], rb[d][idx*4+2], rb[d][idx*4+1], rb[d][idx*4]};
    endfunction

    task automatic check_mem(input int d, input string tag);
        for (int i = 0; i < 16; i++) chk({tag, "/mem"}, mem[d][i], ref_word(d, i));
    endtask

    task automatic set_word(input int d, input int idx, input logic [31:0] val);
        for (int k = 0; k < 4; k++) rb[d][idx*4+k] = val[8*k +: 8];
        pl_d = d; pl_idx = 4'(idx); pl_val = val; pl_en = 1'b1;
        @(negedge clk);
        #1 pl_en = 1'b0;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // One request end to end: reference expectations, drive, monitor, then memory compare.
    task automatic do_req(input int d, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        int size, nrd, nwr, lat, exp_lat, exp_nrd, exp_nwr;
        bit span, ill, got;
        logic [31:0] v, exp_data;
        logic [5:0] ix;
        size = size_of(f3);
        span = (int'(a[1:0]) + size) > 4;
        ill  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]) || (span && d == 1);
        v = 32'd0;
        for (int k = 0; k < size; k++) begin
            ix = 6'(a + 32'(k));
            v  = v | (32'(rb[d][ix]) << (8 * k));
        end
        exp_data = 32'd0;
        if (ill) begin
            exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
        end else if (!st) begin
            exp_lat = span ? 3 : 2; exp_nrd = span ? 2 : 1; exp_nwr = 0;
            exp_data = v;
            if (f3 == 3'b000 && v[7])  exp_data = exp_data | 32'hFFFFFF00;
            if (f3 == 3'b001 && v[15]) exp_data = exp_data | 32'hFFFF0000;
        end else if (f3 == 3'b010 && a[1:0] == 2'b00) begin
            exp_lat = 2; exp_nrd = 0; exp_nwr = 1;
        end else begin
            exp_lat = span ? 5 : 3; exp_nrd = span ? 2 : 1; exp_nwr = span ? 2 : 1;
        end

        @(negedge clk);
        chk({tag, "/ready"}, 32'(req_ready[d]), 32'd1);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid[d] = 1'b1;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;

        got = 1'b0; nrd = 0; nwr = 0; lat = 0;
        for (int n = 1; n <= 12 && !got; n++) begin
            @(negedge clk);
            chk({tag, "/rdwr_excl"}, 32'(mem_rd[d] & mem_wr[d]), 32'd0);
            chk({tag, "/addr_lo"}, 32'(mem_addr[d][1:0]), 32'd0);
            if (mem_rd[d]) nrd++;
            if (mem_wr[d]) nwr++;
            if (resp_valid[d]) begin
                got = 1'b1; lat = n;
                last_rdata = resp_rdata[d]; last_err = resp_err[d]; last_lat = n;
                chk({tag, "/err"}, 32'(resp_err[d]), 32'(ill));
                chk({tag, "/rdata"}, resp_rdata[d], exp_data);
            end
        end
        chk({tag, "/resp_seen"}, 32'(got), 32'd1);
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/nrd"}, 32'(nrd), 32'(exp_nrd));
        chk({tag, "/nwr"}, 32'(nwr), 32'(exp_nwr));
        @(negedge clk);
        chk({tag, "/pulse"}, 32'(resp_valid[d]), 32'd0);
        chk({tag, "/ready_back"}, 32'(req_ready[d]), 32'd1);
        if (!ill && st) begin
            for (int k = 0; k < size; k++) begin
                ix = 6'(a + 32'(k));
                rb[d][ix] = wd[8*k +: 8];
            end
        end
        check_mem(d, tag);
    endtask

    // Store on instance 0 aborted by reset either during its second read or its first write.
    task automatic abort_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             input bit at_wr, input string tag);
        int nrd;
        bit hit;
        logic [5:0] ix;
        @(negedge clk);
        req_store = 1'b1; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        nrd = 0; hit = 1'b0;
        for (int n = 1; n <= 8 && !hit; n++) begin
            @(negedge clk);
            if (mem_rd[0]) nrd++;
            hit = at_wr ? mem_wr[0] : (nrd == 2);
        end
        chk({tag, "/reached"}, 32'(hit), 32'd1);
        if (at_wr) begin
            for (int k = 0; k < size_of(f3); k++) begin
                ix = 6'(a + 32'(k));
                if (((a + 32'(k)) >> 2) == (a >> 2)) rb[0][ix] = wd[8*k +: 8];
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk({tag, "/no_wr"}, 32'(mem_wr[0]), 32'd0);
            chk({tag, "/no_resp"}, 32'(resp_valid[0]), 32'd0);
        end
        chk({tag, "/idle"}, 32'(req_ready[0]), 32'd1);
        check_mem(0, tag);
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [2:0]  f3;
        logic        st;
        rst = 1'b1;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        pl_en = 1'b0; pl_d = 0; pl_idx = 4'd0; pl_val = 32'd0;
        last_rdata = 32'd0; last_lat = 0; last_err = 1'b0;

        // Reset state, with req_valid held high to confirm it is ignored.
        repeat (2) @(negedge clk);
        req_valid[0] = 1'b1; req_addr = 32'h8; req_funct3 = 3'b010;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst/req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst/resp_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst/resp_err", 32'(resp_err[d]), 32'd0);
            chk("rst/resp_rdata", resp_rdata[d], 32'd0);
            chk("rst/mem_addr", mem_addr[d], 32'd0);
            chk("rst/mem_wr_data", mem_wr_data[d], 32'd0);
            chk("rst/mem_wr", 32'(mem_wr[d]), 32'd0);
            chk("rst/mem_rd", 32'(mem_rd[d]), 32'd0);
            chk("rst/mem_mask", 32'(mem_mask[d]), 32'h2);
        end
        rst = 1'b0; req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_ignore/ready", 32'(req_ready[0]), 32'd1);
        chk("rst_ignore/mem_rd", 32'(mem_rd[0]), 32'd0);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) set_word(d, i, $urandom);

        set_word(0, 2, 32'hDEADBEEF);
        do_req(0, 1'b0, 3'b010, 32'h8, 32'h0, "lw_aligned");
        chk("lw_aligned/value", last_rdata, 32'hDEADBEEF);
        chk("lw_aligned/lat", 32'(last_lat), 32'd2);

        set_word(0, 2, 32'h123480FF);
        do_req(0, 1'b0, 3'b000, 32'h9, 32'h0, "lb");
        chk("lb/value", last_rdata, 32'hFFFFFF80);
        do_req(0, 1'b0, 3'b100, 32'h9, 32'h0, "lbu");
        chk("lbu/value", last_rdata, 32'h00000080);

        set_word(0, 1, 32'h11223344);
        do_req(0, 1'b1, 3'b000, 32'h6, 32'hFFFFFFAB, "sb");
        chk("sb/word", mem[0][1], 32'h11AB3344);

        set_word(0, 1, 32'hAABBCCDD);
        set_word(0, 2, 32'h44332211);
        do_req(0, 1'b0, 3'b010, 32'h7, 32'h0, "lw_mis");
        chk("lw_mis/value", last_rdata, 32'h332211AA);
        chk("lw_mis/lat", 32'(last_lat), 32'd3);

        set_word(0, 0, 32'h0); set_word(0, 1, 32'h0);
        do_req(0, 1'b1, 3'b001, 32'h3, 32'h0000BEEF, "sh_mis");
        chk("sh_mis/w0", mem[0][0], 32'hEF000000);
        chk("sh_mis/w1", mem[0][1], 32'h000000BE);
        chk("sh_mis/lat", 32'(last_lat), 32'd5);

        set_word(1, 0, 32'h0); set_word(1, 1, 32'h0);
        do_req(1, 1'b1, 3'b001, 32'h3, 32'h0000BEEF, "sh_na");
        chk("sh_na/err", 32'(last_err), 32'd1);
        chk("sh_na/lat", 32'(last_lat), 32'd1);
        chk("sh_na/w0", mem[1][0], 32'h0);
        chk("sh_na/w1", mem[1][1], 32'h0);

        do_req(0, 1'b0, 3'b011, 32'h4, 32'h0, "f3_011");
        chk("f3_011/err", 32'(last_err), 32'd1);

        do_req(0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, "lw_wrap");
        do_req(0, 1'b1, 3'b010, 32'hFFFFFFFD, 32'h13579BDF, "sw_wrap");
        do_req(0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, "sw_aligned");

        abort_req(3'b001, 32'h3, 32'h00001234, 1'b0, "rst_rd1");
        abort_req(3'b010, 32'h5, 32'h89ABCDEF, 1'b1, "rst_wr0");

        for (int i = 0; i < 160; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFC0 | 32'($urandom_range(0, 63)))
                                             : 32'($urandom_range(0, 63));
            f3 = 3'($urandom_range(0, 7));
            st = 1'($urandom_range(0, 1));
            wd = $urandom;
            do_req((i % 4 == 3) ? 1 : 0, st, f3, a, wd, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

Interface
REQ-001 SHALL have parameter MISALIGN_EN, default 1, meaning that misaligned accesses are split into two word accesses when 1 and reported as errors when 0.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a core load/store request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have port req_store, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_err, output, 1 bit: the request was illegal or misaligned-disallowed; valid with resp_valid.
REQ-012 SHALL have port resp_rdata, output, 32 bits: load result, sign/zero extended; 0 for stores and errors.
REQ-013 SHALL have port mem_addr, output, 32 bits: word-aligned address; bits [1:0] are always 00.
REQ-014 SHALL have port mem_wr_data, output, 32 bits: full word to write.
REQ-015 SHALL have port mem_wr, output, 1 bit: write strobe; memory commits on the falling edge of the same cycle.
REQ-016 SHALL have port mem_rd, output, 1 bit: read strobe.
REQ-017 SHALL have port mem_mask, output, 3 bits: constant 3'b010, since only word accesses are issued.
REQ-018 SHALL have port mem_rdata, input, 32 bits: combinational read data, valid in the same cycle as mem_rd.

Function
REQ-019 SHALL implement the FSM states IDLE, RD0, RD1, WR0, WR1, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 SHALL latch store flag, funct3, addr and wdata on IDLE && req_valid; size = 1/2/4 bytes; w0 = addr[31:2]; span2 = (addr + size - 1)[31:2] != w0.
REQ-021 SHALL treat as illegal: funct3 011/110/111, a store with funct3[2]=1, and span2 with MISALIGN_EN=0; an illegal request SHALL go IDLE->RESP with resp_err=1 and no mem_rd/mem_wr.
REQ-022 SHALL route a legal request from IDLE to RD0, except an aligned SW, which SHALL go directly to WR0 with no read.
REQ-023 In RD0, SHALL drive mem_rd=1 and mem_addr={w0,2'b00}, and capture mem_rdata into buf0; next state RD1 if span2, else WR0 for a store or RESP for a load.
REQ-024 In RD1, SHALL drive mem_rd=1 and mem_addr={w0+1,2'b00} (30-bit wrap: 0x3FFFFFFF+1 -> 0), and capture into buf1; next state WR0 for a store, RESP for a load.
REQ-025 In WR0, SHALL drive mem_wr=1 with buf0, replacing only the bytes of the access that fall in word w0 with the corresponding wdata bytes (little-endian, byte k at addr+k); next state WR1 if span2, else RESP.
REQ-026 In WR1, SHALL drive mem_wr=1 at w0+1 with buf1 merged the same way; next state RESP.
REQ-027 A load result SHALL be assembled from buf1:buf0 starting at byte addr[1:0]; B/H SHALL sign-extend and BU/HU SHALL zero-extend.
REQ-028 In RESP, SHALL assert resp_valid=1 for exactly one cycle with no backpressure, then return to IDLE.
REQ-029 Latency from the acceptance edge to resp_valid SHALL be: aligned load 2 cycles; misaligned load 3; aligned SW 2; aligned SB/SH 3; misaligned store 5; error 1.
REQ-030 mem_rd and mem_wr SHALL never both be 1; outside RD/WR states, mem_addr, mem_wr_data, mem_rd and mem_wr SHALL be 0.

Reset
REQ-031 On rst sampled high, SHALL enter IDLE and clear all outputs: req_ready=1 and mem_mask=010, everything else 0.
REQ-032 Reset mid-operation SHALL abandon the request with no resp_valid; a WR cycle already in progress when rst is sampled SHALL complete its falling-edge write, and no further write SHALL follow.
REQ-033 req_valid SHALL be ignored in any cycle in which rst is high.

Verification
REQ-034 mem[2]=0xDEADBEEF; LW 0x8 -> RD0 at T+1, resp_rdata=0xDEADBEEF at T+2, err=0.
REQ-035 mem[2]=0x123480FF; LB 0x9 -> 0xFFFFFF80; LBU 0x9 -> 0x00000080.
REQ-036 mem[1]=0x11223344; SB 0x6 with wdata 0xAB -> one read then one write; mem[1]=0x11AB3344.
REQ-037 mem[1]=0xAABBCCDD, mem[2]=0x44332211; LW 0x7 -> reads words 1 and 2; resp_rdata=0x332211AA at T+3.
REQ-038 mem[0]=mem[1]=0; SH 0x3 with wdata 0xBEEF -> mem[0]=0xEF000000, mem[1]=0x000000BE, resp at T+5; repeat with MISALIGN_EN=0 -> resp_err=1 at T+1, memory unchanged.
REQ-039 funct3=011 load -> resp_err=1 at T+1, no strobes; rst asserted during RD1 of a misaligned store -> IDLE, no mem_wr, no resp_valid.
